uart_rx: RTL and testbench

Receive-side UART stage: deserialises an 8N1 line (LSB first, 1 start, 8 data, 1 stop) into bytes. It sits directly downstream of the transmitter's serial output, in loopback benches and on the board RX pin, and uses the same bit-period definition as the transmitter. Each received byte is presented with a one-cycle valid strobe plus framing and parity status.

---
 rtl/uart_rx.sv | 157 +++++++++++++++
 tb/tb_uart_rx.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver with a 2-flop synchroniser and mid-bit sampling.
// Define UART_RX_PARITY_EN to expect an even-parity bit before the stop bit.
module uart_rx #(
  parameter int unsigned CLKS_PER_BIT = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_i,
  output logic [7:0] d_o,
  output logic       valid_o,
  output logic       frame_err_o,
  output logic       parity_err_o,
  output logic       busy_o
);

  localparam int unsigned P    = CLKS_PER_BIT + 1;
  localparam int unsigned HALF = P / 2;
  localparam int unsigned CW   = $clog2(P);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0]    bit_idx, bit_idx_n;
  logic [7:0]    shift, shift_n;
  logic [7:0]    d_n;
  logic          valid_n, ferr_n, perr_n, busy_n;
  logic          rx_meta, rx_s, rx_q;
`ifdef UART_RX_PARITY_EN
  logic          par_bit, par_n;
`endif

  // Synchroniser plus one-cycle history for start-edge detection
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_q    <= 1'b1;
    end else begin
      rx_meta <= rx_i;
      rx_s    <= rx_meta;
      rx_q    <= rx_s;
    end
  end

  // State and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= S_IDLE;
      cnt          <= '0;
      bit_idx      <= '0;
      shift        <= '0;
      d_o          <= '0;
      valid_o      <= 1'b0;
      frame_err_o  <= 1'b0;
      parity_err_o <= 1'b0;
      busy_o       <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit      <= 1'b0;
`endif
    end else begin
      state        <= state_n;
      cnt          <= cnt_n;
      bit_idx      <= bit_idx_n;
      shift        <= shift_n;
      d_o          <= d_n;
      valid_o      <= valid_n;
      frame_err_o  <= ferr_n;
      parity_err_o <= perr_n;
      busy_o       <= busy_n;
`ifdef UART_RX_PARITY_EN
      par_bit      <= par_n;
`endif
    end
  end

  // Next-state and output logic
  always_comb begin
    state_n   = state;
    cnt_n     = cnt + CW'(1);
    bit_idx_n = bit_idx;
    shift_n   = shift;
    d_n       = d_o;
    valid_n   = 1'b0;
    ferr_n    = frame_err_o;
    perr_n    = parity_err_o;
`ifdef UART_RX_PARITY_EN
    par_n     = par_bit;
`endif
    case (state)
      S_IDLE: begin
        cnt_n = '0;
        if (rx_q && !rx_s) state_n = S_START;
      end
      S_START: begin
        if (cnt == CW'(HALF)) begin
          cnt_n = '0;
          if (!rx_s) begin
            state_n   = S_DATA;
            bit_idx_n = '0;
          end else begin
            state_n = S_IDLE;
          end
        end
      end
      S_DATA: begin
        if (cnt == CW'(P - 1)) begin
          cnt_n   = '0;
          shift_n = {rx_s, shift[7:1]};
          if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_n = S_PARITY;
`else
            state_n = S_STOP;
`endif
          end else begin
            bit_idx_n = bit_idx + 3'd1;
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (cnt == CW'(P - 1)) begin
          cnt_n   = '0;
          par_n   = rx_s;
          state_n = S_STOP;
        end
      end
`endif
      S_STOP: begin
        // Leave at mid-stop so a back-to-back start edge is not missed
        if (cnt == CW'(P - 1)) begin
          cnt_n   = '0;
          state_n = S_IDLE;
          d_n     = shift;
          valid_n = 1'b1;
          ferr_n  = ~rx_s;
`ifdef UART_RX_PARITY_EN
          perr_n  = ^{shift, par_bit};
`else
          perr_n  = 1'b0;
`endif
        end
      end
      default: begin
        state_n = S_IDLE;
        cnt_n   = '0;
      end
    endcase
    busy_n = (state_n != S_IDLE);
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed bench for uart_rx at CLKS_PER_BIT=4 and 7.
// Honours UART_RX_PARITY_EN when the design is built with it.
module tb_uart_rx;

`ifdef UART_RX_PARITY_EN
  localparam int NB   = 11;
  localparam int LAT4 = 55;
  localparam int LAT7 = 87;
  localparam bit PAR  = 1'b1;
`else
  localparam int NB   = 10;
  localparam int LAT4 = 50;
  localparam int LAT7 = 79;
  localparam bit PAR  = 1'b0;
`endif
  localparam int P4 = 5;
  localparam int P7 = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx4, rx7;
  logic [7:0] d4, d7;
  logic       v4, v7, fe4, fe7, pe4, pe7, b4, b7;

  uart_rx #(.CLKS_PER_BIT(4)) dut4 (
    .clk(clk), .reset(reset), .rx_i(rx4), .d_o(d4), .valid_o(v4),
    .frame_err_o(fe4), .parity_err_o(pe4), .busy_o(b4)
  );
  uart_rx #(.CLKS_PER_BIT(7)) dut7 (
    .clk(clk), .reset(reset), .rx_i(rx7), .d_o(d7), .valid_o(v7),
    .frame_err_o(fe7), .parity_err_o(pe7), .busy_o(b7)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] d;
    logic       fe;
    logic       pe;
    int         cyc;
  } ev_t;
  ev_t q4[$];
  ev_t q7[$];

  always @(negedge clk) begin
    if (v4) q4.push_back('{d4, fe4, pe4, cyc});
    if (v7) q7.push_back('{d7, fe7, pe7, cyc});
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_line(input int which, input logic v);
    if (which == 0) rx4 = v;
    else            rx7 = v;
  endtask

  function automatic int jit_of(input int k, input bit jit);
    if (!jit || k == 0 || k >= NB) return 0;
    return ((k * 5) % 3) - 1;
  endfunction

  // Drives the first nbits of a frame; starts and ends just after a rising edge
  task automatic send(input int which, input logic [7:0] b, input logic stop_b,
                      input logic par_flip, input int nbits, input bit jit, output int t0);
    logic [11:0] fr;
    int p, dur;
    p  = (which == 0) ? P4 : P7;
    fr = '1;
    fr[0]   = 1'b0;
    fr[8:1] = b;
`ifdef UART_RX_PARITY_EN
    fr[9]  = (^b) ^ par_flip;
    fr[10] = stop_b;
`else
    fr[9]  = stop_b;
    if (par_flip) fr[11] = 1'b1;
`endif
    t0 = cyc + 1;
    for (int k = 0; k < nbits; k++) begin
      set_line(which, fr[k]);
      dur = p + jit_of(k + 1, jit) - jit_of(k, jit);
      repeat (dur) @(posedge clk);
      #1;
    end
  endtask

  task automatic check_ev(input int which, input int idx, input logic [7:0] ed,
                          input logic efe, input logic epe, input int t0, input int lat,
                          input string name);
    ev_t e;
    int  sz;
    sz = (which == 0) ? q4.size() : q7.size();
    check({name, "_present"}, 32'(idx < sz), 32'd1);
    if (idx < sz) begin
      e = (which == 0) ? q4[idx] : q7[idx];
      check({name, "_d"},       32'(e.d),      32'(ed));
      check({name, "_ferr"},    32'(e.fe),     32'(efe));
      check({name, "_perr"},    32'(e.pe),     32'(epe));
      check({name, "_latency"}, e.cyc - t0,    lat);
    end
  endtask

  typedef struct {
    logic [7:0] data;
    logic       stop_b;
    logic [7:0] exp_d;
    logic       exp_fe;
  } vec_t;

  initial begin
    vec_t tv[4];
    int   t0s[4];
    int   base, t0, t1;

    tv[0] = '{8'h55, 1'b1, 8'h55, 1'b0};
    tv[1] = '{8'hA3, 1'b1, 8'hA3, 1'b0};
    tv[2] = '{8'h00, 1'b1, 8'h00, 1'b0};
    tv[3] = '{8'hFF, 1'b1, 8'hFF, 1'b0};

    reset = 1'b1;
    rx4   = 1'b1;
    rx7   = 1'b1;
    tick(3);
    check("rst_d4", 32'(d4), 0);   check("rst_v4", 32'(v4), 0);
    check("rst_fe4", 32'(fe4), 0); check("rst_pe4", 32'(pe4), 0);
    check("rst_b4", 32'(b4), 0);
    check("rst_d7", 32'(d7), 0);   check("rst_v7", 32'(v7), 0);
    check("rst_b7", 32'(b7), 0);
    reset = 1'b0;
    tick(5);

    // Back-to-back frames with zero idle between them
    base = q4.size();
    for (int i = 0; i < 4; i++) send(0, tv[i].data, tv[i].stop_b, 1'b0, NB, 1'b0, t0s[i]);
    tick(60);
    check("b2b_count", q4.size() - base, 4);
    for (int i = 0; i < 4; i++)
      check_ev(0, base + i, tv[i].exp_d, tv[i].exp_fe, 1'b0, t0s[i], LAT4, $sformatf("b2b%0d", i));

    // Two-cycle low glitch
    base = q4.size();
    rx4 = 1'b0;
    tick(2);
    rx4 = 1'b1;
    tick(2);
    check("glitch_busy_hi", 32'(b4), 1);
    tick(5);
    check("glitch_busy_lo", 32'(b4), 0);
    tick(80);
    check("glitch_no_valid", q4.size() - base, 0);

    // Stop bit low, then line stuck low, then re-armed by a high-then-low edge
    base = q4.size();
    send(0, 8'h3C, 1'b0, 1'b0, NB, 1'b0, t0);
    tick(200);
    check("ferr_count", q4.size() - base, 1);
    check_ev(0, base, 8'h3C, 1'b1, 1'b0, t0, LAT4, "ferr");
    rx4 = 1'b1;
    tick(10);
    send(0, 8'h81, 1'b1, 1'b0, NB, 1'b0, t1);
    tick(60);
    check("rearm_count", q4.size() - base, 2);
    check_ev(0, base + 1, 8'h81, 1'b0, 1'b0, t1, LAT4, "rearm");

    // Reset during data bit 4 of 0x96
    base = q4.size();
    send(0, 8'h96, 1'b1, 1'b0, 5, 1'b0, t0);
    rx4 = 1'b1;
    tick(2);
    reset = 1'b1;
    #1;
    check("midrst_d", 32'(d4), 0);   check("midrst_v", 32'(v4), 0);
    check("midrst_b", 32'(b4), 0);   check("midrst_fe", 32'(fe4), 0);
    tick(3);
    reset = 1'b0;
    tick(10);
    send(0, 8'h5A, 1'b1, 1'b0, NB, 1'b0, t1);
    tick(60);
    check("midrst_count", q4.size() - base, 1);
    check_ev(0, base, 8'h5A, 1'b0, 1'b0, t1, LAT4, "midrst");

    // Parity good then bad (flip has no effect without parity)
    base = q4.size();
    send(0, 8'h07, 1'b1, 1'b0, NB, 1'b0, t0);
    send(0, 8'h07, 1'b1, 1'b1, NB, 1'b0, t1);
    tick(70);
    check("par_count", q4.size() - base, 2);
    check_ev(0, base,     8'h07, 1'b0, 1'b0, t0, LAT4, "par_good");
    check_ev(0, base + 1, 8'h07, 1'b0, PAR,  t1, LAT4, "par_bad");

    // CLKS_PER_BIT=7 with +/-1 cycle edge jitter
    base = q7.size();
    send(1, 8'hC5, 1'b1, 1'b0, NB, 1'b1, t0);
    tick(100);
    check("jit_count", q7.size() - base, 1);
    check_ev(1, base, 8'hC5, 1'b0, 1'b0, t0, LAT7, "jit");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
